// File: rtl/m68k_bus_master_if.sv
// Request/status side and 68000 bus side of the bus master, grouped for port connection.
// master = the bus initiator; slave = the requester plus the system controller around it.
interface m68k_bus_master_if;
    logic        req;
    logic        req_rw;
    logic [22:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [22:0] addr;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        as;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        dtack;
    logic        berr;

    modport master (
        input  req, req_rw, req_addr, req_be, req_wdata, data_in, dtack, berr,
        output busy, done, err, rdata, addr, data_out, data_oe, as, uds, lds, rw
    );

    modport slave (
        output req, req_rw, req_addr, req_be, req_wdata, data_in, dtack, berr,
        input  busy, done, err, rdata, addr, data_out, data_oe, as, uds, lds, rw
    );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: single-cycle request -> AS/UDS/LDS/RW cycle, ends on DTACK/BERR.
// Optional WAIT-state timeout when BUS_TIMEOUT_EN is defined (length TIMEOUT_CYCLES).
//   state   | meaning
//   S_IDLE  | waiting for a request
//   S_ADDR  | address and RW driven, strobes high
//   S_ASRT  | AS low; read strobes low, write data driven
//   S_WDS   | write data strobes low
//   S_WAIT  | waiting for DTACK/BERR (or timeout)
//   S_TERM  | strobes released, DONE pulse
//   S_RECOV | bus released, back to idle
module m68k_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    m68k_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_ASRT  = 3'd2,
        S_WDS   = 3'd3,
        S_WAIT  = 3'd4,
        S_TERM  = 3'd5,
        S_RECOV = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_write;
    logic [1:0]  r_be;
    logic [22:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_illegal;
    logic        w_timeout;

    assign w_accept  = (r_state == S_IDLE) && bus.req;
    assign w_illegal = (bus.req_be == 2'b00);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Down-counter preloaded outside WAIT; terminal count marks the last allowed WAIT cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

    assign w_timeout = (r_tmo_cnt == '0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_be    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_err   <= w_illegal;
                r_write <= ~bus.req_rw & ~w_illegal;
                r_be    <= bus.req_be;
                if (!w_illegal) begin
                    r_addr <= bus.req_addr;
                    if (!bus.req_rw) begin
                        r_wdata <= bus.req_wdata;
                    end
                end
            end
            if (r_state == S_WAIT) begin
                if (!bus.berr) begin
                    r_err <= 1'b1;
                end else if (!bus.dtack) begin
                    if (!r_write) begin
                        r_rdata <= bus.data_in;
                    end
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.req) w_state_nxt = w_illegal ? S_TERM : S_ADDR;
            S_ADDR:  w_state_nxt = S_ASRT;
            S_ASRT:  w_state_nxt = r_write ? S_WDS : S_WAIT;
            S_WDS:   w_state_nxt = S_WAIT;
            S_WAIT:  if (!bus.berr || !bus.dtack || w_timeout) w_state_nxt = S_TERM;
            S_TERM:  w_state_nxt = S_RECOV;
            S_RECOV: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.as      = 1'b1;
        bus.uds     = 1'b1;
        bus.lds     = 1'b1;
        bus.rw      = 1'b1;
        bus.data_oe = 1'b0;
        case (r_state)
            S_ADDR: begin
                bus.rw = ~r_write;
            end
            S_ASRT: begin
                bus.as      = 1'b0;
                bus.rw      = ~r_write;
                bus.data_oe = r_write;
                if (!r_write) begin
                    {bus.uds, bus.lds} = ~r_be;
                end
            end
            S_WDS, S_WAIT: begin
                bus.as             = 1'b0;
                bus.rw             = ~r_write;
                bus.data_oe        = r_write;
                {bus.uds, bus.lds} = ~r_be;
            end
            S_TERM: begin
                bus.rw      = ~r_write;
                bus.data_oe = r_write;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_TERM);
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;
    assign bus.addr     = r_addr;
    assign bus.data_out = r_wdata;

endmodule
